// File: rtl/jt12_wrfifo.sv
// CPU-to-synthesizer write FIFO with a drain FSM that paces
// data writes on the chip busy flag.
module jt12_wrfifo #(
  parameter int AW     = 3,
  parameter int SETTLE = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_wr,
  input  logic [1:0]    cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic          cpu_full,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic [AW:0]   level,
  output logic          syn_write,
  output logic [1:0]    syn_addr,
  output logic [7:0]    syn_din,
  input  logic          syn_busy
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_WAITB  = 2'd3;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          push;
  logic          drop;
  logic          pop;

  assign cpu_full  = (level == (AW+1)'(DEPTH));
  assign push      = cpu_wr & ~cpu_full;
  assign drop      = cpu_wr & cpu_full;
  assign pop       = (state == S_IDLE) & (level != '0);
  assign syn_write = (state == S_ISSUE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cpu_addr, cpu_din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      // a drop on the same edge beats the clear
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      syn_addr <= '0;
      syn_din  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            state               <= S_ISSUE;
            {syn_addr, syn_din} <= mem[rd_ptr];
          end
        end
        S_ISSUE: begin
          if (syn_addr[0]) begin
            state <= S_SETTLE;
            cnt   <= CW'(SETTLE - 1);
          end else begin
            state <= S_IDLE;
          end
        end
        S_SETTLE: begin
          if (cnt == '0) state <= S_WAITB;
          else           cnt   <= cnt - 1'b1;
        end
        S_WAITB: begin
          if (!syn_busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt12_wrfifo.sv
// Directed bench for jt12_wrfifo: latency, busy pacing,
// overflow, pointer wrap and asynchronous reset.
module tb_jt12_wrfifo;

  localparam int AW = 3;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        cpu_wr   = 1'b0;
  logic [1:0]  cpu_addr = '0;
  logic [7:0]  cpu_din  = '0;
  logic        ovf_clr  = 1'b0;
  logic        syn_busy = 1'b0;
  logic        cpu_full;
  logic        ovf;
  logic [AW:0] level;
  logic        syn_write;
  logic [1:0]  syn_addr;
  logic [7:0]  syn_din;

  int total = 0;
  int bad   = 0;

  logic [9:0] got[$];
  logic [9:0] exp_q[$];

  jt12_wrfifo #(.AW(AW), .SETTLE(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_full  (cpu_full),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .level     (level),
    .syn_write (syn_write),
    .syn_addr  (syn_addr),
    .syn_din   (syn_din),
    .syn_busy  (syn_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && syn_write) got.push_back({syn_addr, syn_din});
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] a, input logic [7:0] d);
    cpu_wr   = 1'b1;
    cpu_addr = a;
    cpu_din  = d;
    step();
    cpu_wr   = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (level != '0 && guard < 300) begin
      step();
      guard++;
    end
    chk("drain_done", 32'(level), 0);
    repeat (6) step();
  endtask

  initial begin
    int n0;
    int i;

    #12;
    chk("rst_level", 32'(level), 0);
    chk("rst_write", 32'(syn_write), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_full", 32'(cpu_full), 0);
    chk("rst_addr", 32'(syn_addr), 0);
    chk("rst_din", 32'(syn_din), 0);
    rst_n = 1'b1;
    step();

    // single address write latency
    got.delete();
    push(2'd0, 8'h28);
    chk("t1_level_after_push", 32'(level), 1);
    chk("t1_no_early_write", 32'(syn_write), 0);
    step();
    chk("t1_write", 32'(syn_write), 1);
    chk("t1_addr", 32'(syn_addr), 0);
    chk("t1_din", 32'(syn_din), 32'h28);
    chk("t1_level_after_pop", 32'(level), 0);
    step();
    chk("t1_write_one_cycle", 32'(syn_write), 0);
    chk("t1_strobes", 32'(got.size()), 1);

    // address then data, busy pacing
    push(2'd0, 8'hB0);
    push(2'd1, 8'h32);
    chk("t2_addr_write", 32'(syn_write), 1);
    chk("t2_addr_din", 32'(syn_din), 32'hB0);
    step();
    chk("t2_gap", 32'(syn_write), 0);
    step();
    chk("t2_data_write", 32'(syn_write), 1);
    chk("t2_data_addr", 32'(syn_addr), 1);
    chk("t2_data_din", 32'(syn_din), 32'h32);
    step();
    syn_busy = 1'b1;
    push(2'd0, 8'h55);
    n0 = got.size();
    repeat (9) step();
    syn_busy = 1'b0;
    step();
    chk("t2_held_while_busy", 32'(got.size() - n0), 0);
    chk("t2_level_pending", 32'(level), 1);
    step();
    chk("t2_after_busy_write", 32'(syn_write), 1);
    chk("t2_after_busy_din", 32'(syn_din), 32'h55);
    step();

    // fill under busy, overflow and clear
    got.delete();
    syn_busy = 1'b1;
    for (int k = 0; k < 9; k++) push(2'd1, 8'(k));
    chk("t3_level_full", 32'(level), 8);
    chk("t3_full", 32'(cpu_full), 1);
    chk("t3_no_ovf_yet", 32'(ovf), 0);
    push(2'd1, 8'hEE);
    push(2'd1, 8'hEF);
    chk("t3_ovf", 32'(ovf), 1);
    chk("t3_level_kept", 32'(level), 8);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", 32'(ovf), 0);
    ovf_clr = 1'b1;
    push(2'd1, 8'hF0);
    ovf_clr = 1'b0;
    chk("t3_set_wins", 32'(ovf), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;

    // full with simultaneous push and pop
    syn_busy = 1'b0;
    step();
    chk("t4_level_before", 32'(level), 8);
    push(2'd1, 8'hAA);
    chk("t4_level_after", 32'(level), 7);
    chk("t4_ovf", 32'(ovf), 1);
    chk("t4_pop_write", 32'(syn_write), 1);
    chk("t4_pop_din", 32'(syn_din), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    drain();
    chk("t4_count", 32'(got.size()), 9);
    for (int k = 0; k < 9; k++)
      chk("t4_order", 32'(got[k]), 32'({2'b01, 8'(k)}));

    // pointer wrap over 20 entries
    got.delete();
    exp_q.delete();
    i = 0;
    while (i < 20) begin
      if (!cpu_full) begin
        cpu_wr   = 1'b1;
        cpu_addr = 2'(i % 2 == 0 ? 0 : 2);
        cpu_din  = 8'(8'h40 + i);
        exp_q.push_back({cpu_addr, cpu_din});
        i++;
      end else begin
        cpu_wr = 1'b0;
      end
      step();
    end
    cpu_wr = 1'b0;
    drain();
    chk("t5_count", 32'(got.size()), 20);
    for (int k = 0; k < 20; k++)
      chk("t5_order", 32'(got[k]), 32'(exp_q[k]));

    // reset in WAITB with queued entries
    syn_busy = 1'b1;
    for (int k = 0; k < 6; k++) push(2'd1, 8'(8'h60 + k));
    chk("t6_level_pre", 32'(level), 5);
    chk("t6_addr_pre", 32'(syn_addr), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_level", 32'(level), 0);
    chk("t6_rst_write", 32'(syn_write), 0);
    chk("t6_rst_addr", 32'(syn_addr), 0);
    chk("t6_rst_din", 32'(syn_din), 0);
    chk("t6_rst_full", 32'(cpu_full), 0);
    chk("t6_rst_ovf", 32'(ovf), 0);
    step();
    step();
    rst_n    = 1'b1;
    syn_busy = 1'b0;
    n0 = got.size();
    repeat (50) step();
    chk("t6_quiet", 32'(got.size() - n0), 0);
    chk("t6_level_quiet", 32'(level), 0);
    push(2'd0, 8'h77);
    step();
    chk("t6_resume_write", 32'(syn_write), 1);
    chk("t6_resume_din", 32'(syn_din), 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
